vm_brew_sched: RTL and testbench
================================

Name: vm_brew_sched

Overview:
Round-robin scheduler that shares a single brewing unit (grinder plus brewer) between NREQ vending front-ends. Each front-end that has completed payment raises a request. The scheduler grants one requester at a time and checks water and beans. It then sequences grind, brew and dispense, and returns a per-requester acknowledge with either coffee or error. It sits between the payment/vending FSMs and the brewer actuators.

Parameters:
NREQ, 2, number of requesting front-ends (2..8)
WATER_W, 5, width of water level input
WATER_PER_CUP, 2, minimum water level required to brew one cup
GRIND_CYC, 3, cycles the grind output is held high (>=1)
BREW_CYC, 4, cycles the brew output is held high (>=1)

Ports:
clk  in  1  system clock, rising edge
rst  in  1  synchronous reset, active-high
req  in  NREQ  per-front-end request level; held until matching ack
water  in  WATER_W  current water tank level (unsigned)
beans  in  1  1 = beans present
gnt  out  NREQ  one-hot owner of brewer; all-zero when idle
grind  out  1  grinder drive
brew  out  1  brewer drive
water_dec  out  1  one-cycle pulse: one cup of water consumed
coffee  out  1  one-cycle pulse: cup dispensed
error  out  1  one-cycle pulse: request rejected (no water/beans)
ack  out  NREQ  one-cycle one-hot pulse to the served requester, concurrent with coffee or error

Behaviour:
- All outputs are registered (Moore). Reset: state IDLE; gnt, ack = 0; grind, brew, water_dec, coffee, error = 0; RR pointer last = NREQ-1, so requester 0 has top priority after reset; timer = 0.
- Reset has priority over everything. Asserting rst mid-service aborts immediately, and all outputs are 0 the cycle after. No ack is issued for the aborted request.
- States: IDLE, CHECK, GRIND, BREW, DISPENSE, FAULT.
- IDLE: if req != 0, select the first set bit searching last+1, last+2, ... modulo NREQ. Register the owner, go to CHECK, and assert gnt = onehot(owner). If req == 0, stay.
- CHECK (1 cycle): sample water and beans. If beans==1 and water >= WATER_PER_CUP (unsigned compare), go to GRIND. Otherwise go to FAULT.
- GRIND: grind=1 for exactly GRIND_CYC cycles, then go to BREW.
- BREW: brew=1 for exactly BREW_CYC cycles. water_dec=1 only in the first BREW cycle. Then go to DISPENSE.
- DISPENSE (1 cycle): coffee=1, ack=onehot(owner). Then go to IDLE with last=owner.
- FAULT (1 cycle): error=1, ack=onehot(owner). Then go to IDLE with last=owner.
- gnt holds onehot(owner) in every non-IDLE state, including DISPENSE and FAULT, and is 0 in IDLE.
- Latency: a request seen in IDLE at edge k gives gnt high from cycle k+1. With defaults, coffee is asserted in cycle k+1+1+GRIND_CYC+BREW_CYC = k+9, and error in cycle k+2.
- Water and beans are sampled only in CHECK; later changes are ignored for the current cup.
- req changes while granted, including the owner dropping req, are ignored, and the service completes. The requester must drop req the cycle after ack. A req still high in the IDLE cycle after ack counts as a new request, but is arbitrated behind the other requesters (fairness).
- Simultaneous requests: exactly one is granted per service. Another requester is never starved for more than NREQ-1 services.
- Pointer wrap: after owner NREQ-1 is served, the search starts at 0.
- At most one of grind, brew, coffee, error is high in any cycle. ack and gnt are always one-hot or zero.

Test Plan:
- Reset then single request: rst=1 for 2 cycles, then req=01, water=10, beans=1. Expect gnt=01 one cycle after; grind high for 3 cycles; brew high for 4 cycles with water_dec in the first brew cycle only; coffee=1 and ack=01 in the 9th cycle after the request was sampled; gnt=00 the next cycle.
- Fault paths: req=10 with water=1, beans=1 → error=1, ack=10 two cycles after sampling, no grind or brew. Repeat with water=31, beans=0 → same error. Repeat with water=2, beans=1 → coffee is produced (boundary case).
- Round-robin: req=11 held continuously and re-raised after each ack. Expect grant order 01, 10, 01, 10, and ack order matching.
- Mid-service input changes: after CHECK passes, drop beans to 0 and water to 0, and drop the owner's req. The service still completes with coffee=1, and the ack goes to the original owner.
- Reset mid-brew: assert rst during the 2nd BREW cycle. Next cycle all outputs are 0 and the state is IDLE. With req=11 after reset, requester 0 is granted first.
- Random soak (200 services): check one-hot gnt and ack, mutual exclusion of grind, brew, coffee and error, exactly one water_dec per coffee, and no starvation.

Source files
------------

// File: rtl/vm_brew_sched.sv
// rtl/vm_brew_sched.sv - round-robin scheduler sharing one grinder/brewer between NREQ front-ends
//
// Grants one requester at a time, checks water and beans once, then runs
// grind -> brew -> dispense (or a one-cycle fault) and acks the owner.
// All outputs are registered.
//
// Ports:
//   i_clk        system clock, rising edge
//   i_rst        synchronous reset, active-high
//   i_req        per-front-end request level, held until matching ack
//   i_water      current water tank level (unsigned)
//   i_beans      1 = beans present
//   o_gnt        one-hot owner of the brewer, zero when idle
//   o_grind      grinder drive
//   o_brew       brewer drive
//   o_water_dec  one-cycle pulse, one cup of water consumed
//   o_coffee     one-cycle pulse, cup dispensed
//   o_error      one-cycle pulse, request rejected
//   o_ack        one-cycle one-hot pulse to the served requester

module vm_brew_sched #(
    parameter int NREQ          = 2,
    parameter int WATER_W       = 5,
    parameter int WATER_PER_CUP = 2,
    parameter int GRIND_CYC     = 3,
    parameter int BREW_CYC      = 4
) (
    input  logic               i_clk,
    input  logic               i_rst,
    input  logic [NREQ-1:0]    i_req,
    input  logic [WATER_W-1:0] i_water,
    input  logic               i_beans,
    output logic [NREQ-1:0]    o_gnt,
    output logic               o_grind,
    output logic               o_brew,
    output logic               o_water_dec,
    output logic               o_coffee,
    output logic               o_error,
    output logic [NREQ-1:0]    o_ack
);

    localparam int OW   = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int TMAX = (GRIND_CYC > BREW_CYC) ? GRIND_CYC : BREW_CYC;
    // The timer only ever holds a load value of TMAX-1 and counts down to 0.
    localparam int TW   = (TMAX > 1) ? $clog2(TMAX) : 1;

    localparam logic [OW-1:0]    LAST_RST   = OW'(NREQ - 1);
    localparam logic [TW-1:0]    GRIND_LOAD = TW'(GRIND_CYC - 1);
    localparam logic [TW-1:0]    BREW_LOAD  = TW'(BREW_CYC - 1);
    localparam logic [TW-1:0]    TIMER_ONE  = TW'(1);
    localparam logic [WATER_W:0] WATER_MIN  = (WATER_W + 1)'(WATER_PER_CUP);
    localparam logic [NREQ-1:0]  ONE_HOT0   = NREQ'(1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CHECK,
        S_GRIND,
        S_BREW,
        S_DISPENSE,
        S_FAULT
    } state_t;

    state_t            r_state;
    logic [OW-1:0]     r_owner;
    logic [OW-1:0]     r_last;
    logic [TW-1:0]     r_timer;
    logic [NREQ-1:0]   r_gnt;
    logic              r_grind;
    logic              r_brew;
    logic              r_water_dec;
    logic              r_coffee;
    logic              r_error;
    logic [NREQ-1:0]   r_ack;

    state_t            w_state_nxt;
    logic [OW-1:0]     w_owner_nxt;
    logic [OW-1:0]     w_last_nxt;
    logic [TW-1:0]     w_timer_nxt;
    logic              w_water_dec_nxt;
    logic [NREQ-1:0]   w_owner_oh;
    logic [OW-1:0]     w_pick;
    logic              w_pick_vld;
    logic              w_supplies_ok;

    // Round-robin pick: first set request searching upward from r_last+1.
    always_comb begin
        int idx;
        idx        = 0;
        w_pick     = r_last;
        w_pick_vld = 1'b0;
        for (int k = 1; k <= NREQ; k++) begin
            idx = int'(r_last) + k;
            if (idx >= NREQ) begin
                idx = idx - NREQ;
            end
            if (!w_pick_vld && i_req[idx[OW-1:0]]) begin
                w_pick     = idx[OW-1:0];
                w_pick_vld = 1'b1;
            end
        end
    end

    assign w_supplies_ok = i_beans && ({1'b0, i_water} >= WATER_MIN);

    always_comb begin
        w_state_nxt     = r_state;
        w_owner_nxt     = r_owner;
        w_last_nxt      = r_last;
        w_timer_nxt     = r_timer;
        w_water_dec_nxt = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_pick_vld) begin
                    w_state_nxt = S_CHECK;
                    w_owner_nxt = w_pick;
                end
            end
            S_CHECK: begin
                if (w_supplies_ok) begin
                    w_state_nxt = S_GRIND;
                    w_timer_nxt = GRIND_LOAD;
                end else begin
                    w_state_nxt = S_FAULT;
                end
            end
            S_GRIND: begin
                if (r_timer == '0) begin
                    w_state_nxt     = S_BREW;
                    w_timer_nxt     = BREW_LOAD;
                    // Registered alongside the first BREW cycle.
                    w_water_dec_nxt = 1'b1;
                end else begin
                    w_timer_nxt = r_timer - TIMER_ONE;
                end
            end
            S_BREW: begin
                if (r_timer == '0) begin
                    w_state_nxt = S_DISPENSE;
                end else begin
                    w_timer_nxt = r_timer - TIMER_ONE;
                end
            end
            S_DISPENSE, S_FAULT: begin
                // The owner moves to lowest priority for the next arbitration.
                w_state_nxt = S_IDLE;
                w_last_nxt  = r_owner;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    assign w_owner_oh = ONE_HOT0 << w_owner_nxt;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state     <= S_IDLE;
            r_owner     <= '0;
            r_last      <= LAST_RST;
            r_timer     <= '0;
            r_gnt       <= '0;
            r_grind     <= 1'b0;
            r_brew      <= 1'b0;
            r_water_dec <= 1'b0;
            r_coffee    <= 1'b0;
            r_error     <= 1'b0;
            r_ack       <= '0;
        end else begin
            r_state     <= w_state_nxt;
            r_owner     <= w_owner_nxt;
            r_last      <= w_last_nxt;
            r_timer     <= w_timer_nxt;
            r_gnt       <= (w_state_nxt != S_IDLE) ? w_owner_oh : '0;
            r_grind     <= (w_state_nxt == S_GRIND);
            r_brew      <= (w_state_nxt == S_BREW);
            r_water_dec <= w_water_dec_nxt;
            r_coffee    <= (w_state_nxt == S_DISPENSE);
            r_error     <= (w_state_nxt == S_FAULT);
            r_ack       <= ((w_state_nxt == S_DISPENSE) || (w_state_nxt == S_FAULT)) ? w_owner_oh : '0;
        end
    end

    assign o_gnt       = r_gnt;
    assign o_grind     = r_grind;
    assign o_brew      = r_brew;
    assign o_water_dec = r_water_dec;
    assign o_coffee    = r_coffee;
    assign o_error     = r_error;
    assign o_ack       = r_ack;

endmodule

// File: tb/tb_vm_brew_sched.sv
// tb/tb_vm_brew_sched.sv - self-checking bench for vm_brew_sched

module tb_vm_brew_sched;

    localparam int NREQ = 2;
    localparam int WW   = 5;
    localparam int WPC  = 2;
    localparam int G    = 3;
    localparam int B    = 4;

    logic            clk = 1'b0;
    logic            rst;
    logic [NREQ-1:0] req;
    logic [WW-1:0]   water;
    logic            beans;
    logic [NREQ-1:0] gnt;
    logic            grind;
    logic            brew;
    logic            water_dec;
    logic            coffee;
    logic            error_o;
    logic [NREQ-1:0] ack;

    always #5 clk = ~clk;

    vm_brew_sched #(
        .NREQ(NREQ), .WATER_W(WW), .WATER_PER_CUP(WPC), .GRIND_CYC(G), .BREW_CYC(B)
    ) dut (
        .i_clk(clk), .i_rst(rst), .i_req(req), .i_water(water), .i_beans(beans),
        .o_gnt(gnt), .o_grind(grind), .o_brew(brew), .o_water_dec(water_dec),
        .o_coffee(coffee), .o_error(error_o), .o_ack(ack)
    );

    int n_chk   = 0;
    int n_fail  = 0;
    int cyc     = 0;
    int n_grind = 0;
    int n_brew  = 0;
    int n_wdec  = 0;
    int n_coffee = 0;
    int n_error = 0;
    logic [NREQ-1:0] keep = '0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // Transaction-level model: a service is a numbered run of cycles after
    // the grant (t=0 is the check cycle); outputs follow from t and the
    // supplies decision.
    initial begin
        bit              m_valid;
        bit              m_busy;
        bit              m_ok;
        bit              found;
        int              m_t;
        int              m_end;
        int              m_owner;
        int              m_last;
        int              idx;
        int              wait_cnt [NREQ];
        logic [NREQ-1:0] oh;
        logic [NREQ-1:0] e_gnt;
        logic [NREQ-1:0] e_ack;
        logic            e_grind;
        logic            e_brew;
        logic            e_wdec;
        logic            e_coffee;
        logic            e_error;
        m_valid = 0; m_busy = 0; m_ok = 0; m_t = 0; m_end = 0;
        m_owner = 0; m_last = NREQ - 1;
        for (int i = 0; i < NREQ; i++) wait_cnt[i] = 0;
        forever begin
            @(negedge clk);
            cyc++;
            if (rst === 1'b1) begin
                m_valid = 1; m_busy = 0; m_last = NREQ - 1;
                for (int i = 0; i < NREQ; i++) wait_cnt[i] = 0;
            end else if (m_busy) begin
                if (m_t == 0) begin
                    m_ok  = beans && (int'(water) >= WPC);
                    m_end = m_ok ? (G + B + 1) : 1;
                end
                if (m_t >= 1 && m_t == m_end) begin
                    m_busy = 0;
                    m_last = m_owner;
                end else begin
                    m_t++;
                end
            end else if (req != '0) begin
                found = 0;
                for (int k = 1; k <= NREQ; k++) begin
                    idx = (m_last + k) % NREQ;
                    if (!found && req[idx]) begin
                        m_owner = idx;
                        found   = 1;
                    end
                end
                m_busy = 1;
                m_t    = 0;
            end

            oh       = NREQ'(1) << m_owner;
            e_gnt    = m_busy ? oh : '0;
            e_grind  = m_busy && m_t >= 1 && m_ok && m_t <= G;
            e_brew   = m_busy && m_ok && m_t >= G + 1 && m_t <= G + B;
            e_wdec   = m_busy && m_ok && m_t == G + 1;
            e_coffee = m_busy && m_ok && m_t == G + B + 1;
            e_error  = m_busy && !m_ok && m_t == 1;
            e_ack    = (e_coffee || e_error) ? oh : '0;

            if (m_valid) begin
                chk("gnt", 32'(gnt), 32'(e_gnt));
                chk("ack", 32'(ack), 32'(e_ack));
                chk("grind", 32'(grind), 32'(e_grind));
                chk("brew", 32'(brew), 32'(e_brew));
                chk("water_dec", 32'(water_dec), 32'(e_wdec));
                chk("coffee", 32'(coffee), 32'(e_coffee));
                chk("error", 32'(error_o), 32'(e_error));
                chk("gnt_onehot0", 32'($onehot0(gnt)), 32'd1);
                chk("ack_onehot0", 32'($onehot0(ack)), 32'd1);
                chk("drive_exclusive", 32'($onehot0({grind, brew, coffee, error_o})), 32'd1);
                n_grind  += int'(grind === 1'b1);
                n_brew   += int'(brew === 1'b1);
                n_wdec   += int'(water_dec === 1'b1);
                n_coffee += int'(coffee === 1'b1);
                n_error  += int'(error_o === 1'b1);
                if (e_ack != '0) begin
                    for (int i = 0; i < NREQ; i++) begin
                        if (i == m_owner) begin
                            wait_cnt[i] = 0;
                        end else if (req[i]) begin
                            wait_cnt[i]++;
                            chk("no_starvation", 32'(wait_cnt[i] <= NREQ - 1), 32'd1);
                        end else begin
                            wait_cnt[i] = 0;
                        end
                    end
                end
            end
        end
    end

    // Inputs change 2 time units after the falling edge; an acked requester
    // drops its request (or keeps it, per keep) for the following cycle.
    task automatic step();
        @(negedge clk);
        #2;
        for (int i = 0; i < NREQ; i++) begin
            if (ack[i]) req[i] = keep[i];
        end
    endtask

    task automatic wait_ack(output logic [NREQ-1:0] a);
        bit got;
        got = 0;
        a   = '0;
        for (int n = 0; n < 64 && !got; n++) begin
            step();
            if (ack != '0) begin
                a   = ack;
                got = 1;
            end
        end
        chk("ack_within_budget", 32'(got), 32'd1);
    endtask

    task automatic run_one(input string nm, input logic [NREQ-1:0] r, input logic [WW-1:0] w,
                           input logic bn, input int exp_lat, input bit exp_cup);
        int g0, b0, w0, c0, e0, t0;
        logic [NREQ-1:0] a;
        g0 = n_grind; b0 = n_brew; w0 = n_wdec; c0 = n_coffee; e0 = n_error;
        req = r; water = w; beans = bn; keep = '0;
        t0 = cyc;
        step();
        chk({nm, "_gnt_next"}, 32'(gnt), 32'(r));
        wait_ack(a);
        chk({nm, "_latency"}, 32'(cyc - t0), 32'(exp_lat));
        chk({nm, "_ack"}, 32'(a), 32'(r));
        chk({nm, "_coffee_cnt"}, 32'(n_coffee - c0), exp_cup ? 32'd1 : 32'd0);
        chk({nm, "_error_cnt"}, 32'(n_error - e0), exp_cup ? 32'd0 : 32'd1);
        chk({nm, "_grind_cyc"}, 32'(n_grind - g0), exp_cup ? 32'(G) : 32'd0);
        chk({nm, "_brew_cyc"}, 32'(n_brew - b0), exp_cup ? 32'(B) : 32'd0);
        chk({nm, "_wdec_cnt"}, 32'(n_wdec - w0), exp_cup ? 32'd1 : 32'd0);
        step();
        chk({nm, "_gnt_idle"}, 32'(gnt), 32'd0);
    endtask

    initial begin
        logic [NREQ-1:0] a;
        logic [NREQ-1:0] rr_exp [4];
        int c0, w0, s0;
        rr_exp[0] = 2'b01; rr_exp[1] = 2'b10; rr_exp[2] = 2'b01; rr_exp[3] = 2'b10;

        rst = 1'b1; req = '0; water = 5'd10; beans = 1'b1;
        step();
        step();
        chk("reset_gnt", 32'(gnt), 32'd0);
        chk("reset_ack", 32'(ack), 32'd0);
        chk("reset_drives", 32'({grind, brew, water_dec, coffee, error_o}), 32'd0);
        rst = 1'b0;
        step();

        run_one("single", 2'b01, 5'd10, 1'b1, 9, 1'b1);
        run_one("low_water", 2'b10, 5'd1, 1'b1, 2, 1'b0);
        run_one("no_beans", 2'b10, 5'd31, 1'b0, 2, 1'b0);
        run_one("water_boundary", 2'b10, 5'd2, 1'b1, 9, 1'b1);

        water = 5'd10; beans = 1'b1;
        req = 2'b11; keep = 2'b11;
        for (int i = 0; i < 4; i++) begin
            if (i == 3) keep = '0;
            wait_ack(a);
            chk("rr_order", 32'(a), 32'(rr_exp[i]));
        end
        req = '0;
        step();

        c0 = n_coffee;
        req = 2'b01; water = 5'd10; beans = 1'b1; keep = '0;
        step();
        step();
        beans = 1'b0; water = 5'd0; req = '0;
        wait_ack(a);
        chk("late_change_ack", 32'(a), 32'd1);
        chk("late_change_coffee", 32'(n_coffee - c0), 32'd1);
        step();

        req = 2'b01; water = 5'd10; beans = 1'b1; keep = '0;
        for (int i = 0; i < 6; i++) step();
        chk("second_brew_cycle", 32'(brew), 32'd1);
        rst = 1'b1;
        step();
        chk("abort_gnt", 32'(gnt), 32'd0);
        chk("abort_ack", 32'(ack), 32'd0);
        chk("abort_drives", 32'({grind, brew, water_dec, coffee, error_o}), 32'd0);
        rst = 1'b0; req = 2'b11;
        step();
        chk("post_reset_first_gnt", 32'(gnt), 32'd1);
        wait_ack(a);
        chk("post_reset_ack0", 32'(a), 32'd1);
        wait_ack(a);
        chk("post_reset_ack1", 32'(a), 32'd2);
        step();

        s0 = n_coffee + n_error; c0 = n_coffee; w0 = n_wdec; keep = '0;
        for (int n = 0; n < 20000 && (n_coffee + n_error - s0) < 200; n++) begin
            step();
            water = WW'(($urandom_range(0, 3) == 0) ? $urandom_range(0, 3) : $urandom_range(2, 31));
            beans = ($urandom_range(0, 7) != 0);
            for (int i = 0; i < NREQ; i++) begin
                if (!req[i] && !ack[i] && $urandom_range(0, 3) == 0) req[i] = 1'b1;
            end
        end
        chk("soak_services", 32'((n_coffee + n_error - s0) >= 200), 32'd1);
        chk("soak_wdec_per_coffee", 32'(n_wdec - w0), 32'(n_coffee - c0));

        req = '0;
        repeat (16) step();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
